// File: rtl/acumulador_desplazamiento_if.sv
// Bus between the displacement accumulator and its user: sensor input,
// circumference/trip controls and all measurement outputs.
interface acumulador_desplazamiento_if #(
  parameter int unsigned CIRC_W = 16,
  parameter int unsigned DIST_W = 24,
  parameter int unsigned PER_W  = 24
);
  logic              impulso_iman;
  logic [CIRC_W-1:0] circunferencia;
  logic              cargar_circ;
  logic              borrar_parcial;
  logic [DIST_W-1:0] desp_total_m;
  logic [9:0]        desp_total_mm;
  logic [DIST_W-1:0] desp_parcial_m;
  logic [PER_W-1:0]  periodo;
  logic              periodo_valido;
  logic              pulso_valido;
  logic              parado;
  logic              ocupado;
  logic              saturado;
  logic              desbordado;

  modport master (
    output impulso_iman, circunferencia, cargar_circ, borrar_parcial,
    input  desp_total_m, desp_total_mm, desp_parcial_m, periodo, periodo_valido,
    input  pulso_valido, parado, ocupado, saturado, desbordado
  );

  modport slave (
    input  impulso_iman, circunferencia, cargar_circ, borrar_parcial,
    output desp_total_m, desp_total_mm, desp_parcial_m, periodo, periodo_valido,
    output pulso_valido, parado, ocupado, saturado, desbordado
  );
endinterface

// File: rtl/acumulador_desplazamiento.sv
// Fixed-point displacement accumulator: synchronises and debounces the
// magnet pulse, adds the wheel circumference per pulse into total/trip
// odometers (metres + mm remainder) and measures the inter-pulse period.
module acumulador_desplazamiento #(
  parameter int unsigned CIRC_W     = 16,
  parameter int unsigned DIST_W     = 24,
  parameter int unsigned PER_W      = 24,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned CIRC_DEF   = 2000
) (
  input  logic clock,
  input  logic reset_n,
  acumulador_desplazamiento_if.slave bus
);
  localparam int unsigned REM_W = CIRC_W + 1;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DIST_W-1:0] DIST_MAX = '1;
  localparam logic [PER_W-1:0]  PER_MAX  = '1;
  localparam logic [REM_W-1:0]  MIL      = REM_W'(1000);
  localparam logic [DEB_W-1:0]  DEB_LIM  = DEB_W'(DEB_CYCLES);

  typedef enum logic [1:0] {DEB_BAJO, DEB_SUBE, DEB_ALTO, DEB_BAJA} deb_t;
  typedef enum logic [1:0] {ACC_IDLE, ACC_SUMA, ACC_NORM} acc_t;

  logic sync1_q, sync2_q;
  deb_t deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic pulso_q, pulso_d;

  acc_t acc_q, acc_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DIST_W-1:0] total_q, total_d, trip_q, trip_d;
  logic [CIRC_W-1:0] circ_q, circ_d, sh_q, sh_d;
  logic sh_pend_q, sh_pend_d, pend_q, pend_d;
  logic desb_q, desb_d, sat_q, sat_d, ocup_q;

  logic [PER_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic pv_q, pv_d, parado_q, parado_d;

  // Two-flop synchroniser for the asynchronous sensor
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.impulso_iman;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level is accepted after DEB_CYCLES consecutive samples
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    pulso_d   = 1'b0;
    unique case (deb_q)
      DEB_BAJO: if (sync2_q) begin
        deb_d     = DEB_SUBE;
        deb_cnt_d = DEB_W'(1);
      end
      DEB_SUBE: begin
        if (!sync2_q) deb_d = DEB_BAJO;
        else if (deb_cnt_q + DEB_W'(1) == DEB_LIM) begin
          deb_d   = DEB_ALTO;
          pulso_d = 1'b1;
        end else deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      DEB_ALTO: if (!sync2_q) begin
        deb_d     = DEB_BAJA;
        deb_cnt_d = DEB_W'(1);
      end
      DEB_BAJA: begin
        if (sync2_q) deb_d = DEB_ALTO;
        else if (deb_cnt_q + DEB_W'(1) == DEB_LIM) deb_d = DEB_BAJO;
        else deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      default: deb_d = DEB_BAJO;
    endcase
  end

  // Debounce state and confirmed-pulse strobe registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_q     <= DEB_BAJO;
      deb_cnt_q <= '0;
      pulso_q   <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      pulso_q   <= pulso_d;
    end
  end

  // Accumulator: add circumference once, then peel off one metre per cycle
  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    total_d   = total_q;
    trip_d    = trip_q;
    pend_d    = pend_q;
    desb_d    = desb_q;
    circ_d    = circ_q;
    sh_d      = sh_q;
    sh_pend_d = sh_pend_q;
    unique case (acc_q)
      ACC_IDLE: if (pulso_q || pend_q) begin
        acc_d  = ACC_SUMA;
        // a fresh pulse arriving with one already pending becomes the new pending one
        pend_d = pulso_q && pend_q;
      end
      ACC_SUMA: begin
        rem_d = rem_q + REM_W'(circ_q);
        acc_d = ACC_NORM;
      end
      ACC_NORM: begin
        if (rem_q >= MIL) begin
          rem_d  = rem_q - MIL;
          trip_d = trip_q + DIST_W'(1);
          if (total_q != DIST_MAX) total_d = total_q + DIST_W'(1);
        end else acc_d = ACC_IDLE;
      end
      default: acc_d = ACC_IDLE;
    endcase
    if (acc_q != ACC_IDLE && pulso_q) begin
      if (pend_q) desb_d = 1'b1;
      else pend_d = 1'b1;
    end
    if (bus.borrar_parcial) trip_d = '0;
    // circumference changes only take effect between accumulations
    if (acc_q == ACC_IDLE) begin
      if (bus.cargar_circ) begin
        circ_d    = bus.circunferencia;
        sh_pend_d = 1'b0;
      end else if (sh_pend_q) begin
        circ_d    = sh_q;
        sh_pend_d = 1'b0;
      end
    end else if (bus.cargar_circ) begin
      sh_d      = bus.circunferencia;
      sh_pend_d = 1'b1;
    end
    sat_d = sat_q || (total_d == DIST_MAX);
  end

  // Accumulator state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= ACC_IDLE;
      rem_q     <= '0;
      total_q   <= '0;
      trip_q    <= '0;
      pend_q    <= 1'b0;
      desb_q    <= 1'b0;
      sat_q     <= 1'b0;
      circ_q    <= CIRC_W'(CIRC_DEF);
      sh_q      <= '0;
      sh_pend_q <= 1'b0;
      ocup_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      total_q   <= total_d;
      trip_q    <= trip_d;
      pend_q    <= pend_d;
      desb_q    <= desb_d;
      sat_q     <= sat_d;
      circ_q    <= circ_d;
      sh_q      <= sh_d;
      sh_pend_q <= sh_pend_d;
      ocup_q    <= (acc_d != ACC_IDLE);
    end
  end

  // Period counter: saturating free-run, restarted by each confirmed pulse
  always_comb begin
    cnt_d    = (cnt_q == PER_MAX) ? cnt_q : cnt_q + PER_W'(1);
    parado_d = parado_q || (cnt_d == PER_MAX);
    per_d    = per_q;
    pv_d     = 1'b0;
    if (pulso_q) begin
      if (!parado_q) begin
        per_d = cnt_q + PER_W'(1);
        pv_d  = 1'b1;
      end
      cnt_d    = '0;
      parado_d = 1'b0;
    end
  end

  // Period registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      per_q    <= '0;
      pv_q     <= 1'b0;
      parado_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      pv_q     <= pv_d;
      parado_q <= parado_d;
    end
  end

  assign bus.desp_total_m   = total_q;
  assign bus.desp_total_mm  = rem_q[9:0];
  assign bus.desp_parcial_m = trip_q;
  assign bus.periodo        = per_q;
  assign bus.periodo_valido = pv_q;
  assign bus.pulso_valido   = pulso_q;
  assign bus.parado         = parado_q;
  assign bus.ocupado        = ocup_q;
  assign bus.saturado       = sat_q;
  assign bus.desbordado     = desb_q;
endmodule

// File: doc/acumulador_desplazamiento.md
Name: acumulador_desplazamiento

Overview:
- Fixed-point successor to the float-IP displacement accumulator of the velocimetro. No floating-point cores.
- Conditions the raw magnet pulse: 2-flop synchroniser, then a debounce FSM.
- Each confirmed pulse adds the wheel circumference (mm) to a total odometer and a clearable trip odometer, both in metres plus a mm remainder.
- Also measures the inter-pulse period in clock cycles for the downstream speed block.

Parameters:
- CIRC_W, 16: circumference width, mm.
- DIST_W, 24: metre counter width (total and trip).
- PER_W, 24: period counter width.
- DEB_CYCLES, 1000: consecutive stable samples needed to accept a level change; must be ≥2.
- CIRC_DEF, 2000: circumference loaded at reset, mm.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- impulso_iman  in  1  raw magnet sensor, asynchronous.
- circunferencia  in  CIRC_W  new circumference, mm.
- cargar_circ  in  1  1-cycle strobe: load circunferencia.
- borrar_parcial  in  1  1-cycle strobe: clear the trip odometer.
- desp_total_m  out  DIST_W  total distance, metres.
- desp_total_mm  out  10  total remainder, 0..999 mm.
- desp_parcial_m  out  DIST_W  trip distance, metres.
- periodo  out  PER_W  cycles between the last two valid pulses.
- periodo_valido  out  1  1-cycle strobe when periodo updates.
- pulso_valido  out  1  1-cycle strobe per confirmed rising edge.
- parado  out  1  period counter saturated (no motion).
- ocupado  out  1  accumulator not in ACC_IDLE.
- saturado  out  1  sticky: total metres hit all-ones.
- desbordado  out  1  sticky: a pulse was dropped.

Behaviour:
- Reset values (async on reset_n=0):
  - all counters and outputs 0, except parado=1;
  - circ_reg=CIRC_DEF;
  - FSMs in DEB_BAJO and ACC_IDLE;
  - pending flag clear.
- Synchroniser: two flops; s = second stage.
- Debounce FSM:
  - DEB_BAJO: s=1 → DEB_SUBE with counter=1.
  - DEB_SUBE: s=0 → DEB_BAJO. Counter reaching DEB_CYCLES → DEB_ALTO and pulso_valido=1 for that cycle.
  - DEB_ALTO: s=0 → DEB_BAJA with counter=1.
  - DEB_BAJA: s=1 → DEB_ALTO. Counter reaching DEB_CYCLES → DEB_BAJO.
  - Only rising edges generate pulses.
- Accumulator FSM (rem is a CIRC_W+1-bit register):
  - ACC_IDLE: on pulso_valido or pending → ACC_SUMA; clear pending.
  - ACC_SUMA, 1 cycle: rem <= rem + circ_reg; → ACC_NORM.
  - ACC_NORM: if rem ≥ 1000, rem -= 1000 and increment total and trip metres (one metre per cycle); else → ACC_IDLE.
  - Latency from pulso_valido to final outputs = 2 + floor((rem_prev + circ)/1000) cycles.
  - desp_total_mm = rem[9:0], valid whenever ocupado=0.
- Pulse during ACC_SUMA/ACC_NORM: set pending (depth 1). Pulse while pending already set: drop it and set desbordado.
- Saturation:
  - Total metres at all-ones stay there and saturado=1; rem keeps normalising.
  - Trip metres wrap modulo 2^DIST_W.
- borrar_parcial: trip = 0. If it coincides with a trip increment, clear wins and that increment is lost.
- cargar_circ:
  - In ACC_IDLE: circ_reg <= circunferencia next cycle.
  - Otherwise: latch the value into a shadow register and apply on the next ACC_IDLE entry. Last strobe wins.
  - circunferencia=0 is legal (pulse adds nothing).
- Period counter:
  - Increments every cycle and saturates at all-ones; on saturation parado=1.
  - On pulso_valido: if parado=0, periodo <= count+1 and periodo_valido=1. Counter restarts at 0 and parado clears.
  - The first pulse after reset or after parado produces no periodo_valido.
- Reset mid-operation aborts any FSM state immediately. No partial sums survive.

Test Plan:
1. DEB_CYCLES=4; impulso_iman high for 3 cycles, low, repeated 5× → no pulso_valido, all counters 0.
2. circ=CIRC_DEF=2000, 3 clean pulses → total_m=6, mm=0, parcial_m=6. Then cargar_circ with 1500, 3 pulses → total_m=10, mm=500.
3. circ=65535, one pulse → ocupado for 67 cycles; final total_m=65, mm=535. A second pulse inside that window is processed via pending (total_m=131, mm=70). A third pulse while pending is set → desbordado=1.
4. Clean pulses 100 cycles apart → first pulse gives no periodo_valido; second gives periodo=100 with periodo_valido. Then 2^PER_W idle cycles (PER_W=8 in sim) → parado=1; next pulse gives no periodo_valido.
5. DIST_W=4, circ=1000, 17 pulses → total_m=15 with saturado=1; parcial_m wraps to 1. borrar_parcial in the same cycle as a trip increment → parcial_m=0.
6. reset_n low during ACC_NORM → all outputs 0 and parado=1 asynchronously. After release, one pulse with circ=2000 → total_m=2.
